// File: rtl/ysyx_22040759_if_axi_rd_if.sv
// ----------------------------------------------------------------------------
// ysyx_22040759_if_axi_rd_if
// Bundles the fetch request/response handshake and the AXI4 read-address and
// read-data channels used by the instruction-fetch read bridge.
//
// Signal groups:
//   fetch side : if_valid, inst_addr, if_size  (IF stage -> bridge)
//                if_ready, if_data_read, if_resp (bridge -> IF stage)
//   AR channel : arvalid, araddr, arid, arlen, arsize, arburst (bridge -> xbar)
//                arready (xbar -> bridge)
//   R channel  : rready (bridge -> xbar)
//                rvalid, rdata, rresp, rlast, rid (xbar -> bridge)
//
// Modports:
//   master : the bridge's view (it is the AXI master and the fetch responder)
//   slave  : the environment's view (IF stage plus AXI slave/crossbar)
// ----------------------------------------------------------------------------
interface ysyx_22040759_if_axi_rd_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              if_valid;
   logic [ADDR_W-1:0] inst_addr;
   logic [1:0]        if_size;
   logic              if_ready;
   logic [DATA_W-1:0] if_data_read;
   logic [1:0]        if_resp;

   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [3:0]        arid;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;

   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic [3:0]        rid;

   modport master (
      input  if_valid, inst_addr, if_size,
      output if_ready, if_data_read, if_resp,
      output arvalid, araddr, arid, arlen, arsize, arburst,
      input  arready,
      output rready,
      input  rvalid, rdata, rresp, rlast, rid
   );

   modport slave (
      output if_valid, inst_addr, if_size,
      input  if_ready, if_data_read, if_resp,
      input  arvalid, araddr, arid, arlen, arsize, arburst,
      output arready,
      input  rready,
      output rvalid, rdata, rresp, rlast, rid
   );
endinterface

// File: rtl/ysyx_22040759_if_axi_rd.sv
// ----------------------------------------------------------------------------
// ysyx_22040759_if_axi_rd
// Instruction-fetch AXI4 read bridge. Turns one IF fetch request into a single
// beat AR/R transaction and hands back the selected 32-bit instruction in
// bits [31:0] of if_data_read, with if_ready pulsing for one cycle.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-low reset (0 = reset)
//   bus  : ysyx_22040759_if_axi_rd_if.master (fetch handshake + AXI AR/R)
//
// Optional feature (macro YSYX_22040759_IF_LINE_BUF_EN):
//   One-entry 64-bit line buffer tagged by address[ADDR_W-1:3]. A fetch that
//   hits the buffer completes from IDLE straight to DONE with no AXI traffic.
//   Filled on every OKAY beat, invalidated by reset or an error beat.
//
// Only DATA_W = 64 is supported.
// ----------------------------------------------------------------------------
module ysyx_22040759_if_axi_rd #(
   parameter logic [3:0] AXI_ID = 4'd0,
   parameter int         ADDR_W = 64,
   parameter int         DATA_W = 64
) (
   input logic clk,
   input logic rst,
   ysyx_22040759_if_axi_rd_if.master bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AR   = 2'd1,
      S_R    = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic              r_arvalid;
   logic              r_rready;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_resp;
   logic              w_unused;

   // Pick the 32-bit instruction lane out of a 64-bit line, zero-extended.
   function automatic logic [DATA_W-1:0] f_lane_sel(input logic [DATA_W-1:0] i_line,
                                                    input logic              i_hi);
      logic [DATA_W-1:0] w_word;
      w_word = {DATA_W{1'b0}};
      if (i_hi) begin
         w_word[31:0] = i_line[63:32];
      end else begin
         w_word[31:0] = i_line[31:0];
      end
      return w_word;
   endfunction

`ifdef YSYX_22040759_IF_LINE_BUF_EN
   logic [DATA_W-1:0] r_lb_data;
   logic [ADDR_W-4:0] r_lb_tag;
   logic              r_lb_valid;
   logic              w_lb_hit;

   assign w_lb_hit = r_lb_valid && (bus.inst_addr[ADDR_W-1:3] == r_lb_tag);

   // Line buffer: capture every OKAY beat, drop the entry on an error beat.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_lb_valid <= 1'b0;
         r_lb_tag   <= {(ADDR_W-3){1'b0}};
         r_lb_data  <= {DATA_W{1'b0}};
      end else if ((r_state == S_R) && bus.rvalid) begin
         if (bus.rresp == 2'b00) begin
            r_lb_valid <= 1'b1;
            r_lb_tag   <= r_addr[ADDR_W-1:3];
            r_lb_data  <= bus.rdata;
         end else begin
            r_lb_valid <= 1'b0;
         end
      end else begin
         r_lb_valid <= r_lb_valid;
      end
   end
`endif

   // Fetch FSM: one outstanding single-beat read at a time.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_addr    <= {ADDR_W{1'b0}};
         r_size    <= 2'b00;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_data    <= {DATA_W{1'b0}};
         r_resp    <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.if_valid) begin
                  r_addr <= bus.inst_addr;
                  r_size <= bus.if_size;
`ifdef YSYX_22040759_IF_LINE_BUF_EN
                  if (w_lb_hit) begin
                     r_data  <= f_lane_sel(r_lb_data, bus.inst_addr[2]);
                     r_resp  <= 2'b00;
                     r_state <= S_DONE;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= S_AR;
                  end
`else
                  r_arvalid <= 1'b1;
                  r_state   <= S_AR;
`endif
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_AR: begin
               // arvalid is held (with a stable address) until accepted.
               if (bus.arready) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_R;
               end else begin
                  r_state <= S_AR;
               end
            end
            S_R: begin
               // The beat is treated as final whatever rlast says.
               if (bus.rvalid) begin
                  r_rready <= 1'b0;
                  r_data   <= f_lane_sel(bus.rdata, r_addr[2]);
                  r_resp   <= bus.rresp;
                  r_state  <= S_DONE;
               end else begin
                  r_state <= S_R;
               end
            end
            S_DONE: begin
               // Whether delivered or discarded, the result lives one cycle.
               r_state <= S_IDLE;
            end
            default: begin
               r_state   <= S_IDLE;
               r_arvalid <= 1'b0;
               r_rready  <= 1'b0;
            end
         endcase
      end
   end

   // Completion is only signalled if the IF still asks for the same address
   // in the DONE cycle; a redirect or a dropped request discards the result.
   assign bus.if_ready     = (r_state == S_DONE) && bus.if_valid &&
                             (bus.inst_addr == r_addr);
   assign bus.if_data_read = r_data;
   assign bus.if_resp      = r_resp;

   assign bus.arvalid = r_arvalid;
   assign bus.araddr  = r_addr;
   assign bus.arid    = AXI_ID;
   assign bus.arlen   = 8'd0;
   assign bus.arsize  = {1'b0, r_size};
   assign bus.arburst = 2'b01;
   assign bus.rready  = r_rready;

   // rid and rlast carry no information for a single-beat, single-ID master.
   assign w_unused = &{1'b0, bus.rid, bus.rlast};

endmodule

// File: tb/tb_ysyx_22040759_if_axi_rd.sv
module tb_ysyx_22040759_if_axi_rd;

`ifdef YSYX_22040759_IF_LINE_BUF_EN
   localparam bit LB_EN = 1'b1;
`else
   localparam bit LB_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ysyx_22040759_if_axi_rd_if bus ();
   ysyx_22040759_if_axi_rd dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk = 0;
   int n_err = 0;

   // AXI slave knobs
   int          cfg_ar = 0;
   int          cfg_r  = 0;
   logic        cfg_rlast = 1'b1;
   logic [63:0] err_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
   logic [1:0]  err_code  = 2'b00;
   int          ar_cnt = 0;

   // memory contents and line-buffer reference model
   logic [63:0] mem [logic [60:0]];
   logic        mdl_lb_valid = 1'b0;
   logic [60:0] mdl_lb_line  = 61'd0;

   int          ar_wait = 0;
   int          r_wait  = 0;
   bit          s_pend  = 1'b0;
   bit          s_seen  = 1'b0;
   logic [63:0] s_addr  = 64'd0;

   function automatic logic [63:0] line_data(input logic [63:0] a);
      logic [60:0] k;
      k = a[63:3];
      if (!mem.exists(k)) mem[k] = {$urandom, $urandom};
      return mem[k];
   endfunction

   function automatic logic [63:0] expect_word(input logic [63:0] a);
      logic [63:0] ln;
      ln = line_data(a);
      return a[2] ? {32'h0, ln[63:32]} : {32'h0, ln[31:0]};
   endfunction

   function automatic bit model_hit(input logic [63:0] a);
      return LB_EN && mdl_lb_valid && (mdl_lb_line == a[63:3]);
   endfunction

   // behavioural AXI slave; reset together with the bridge
   always @(negedge clk) begin
      if (!rst) begin
         bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 64'd0;
         bus.rresp = 2'b00; bus.rlast = 1'b0; bus.rid = 4'd0;
         s_pend = 1'b0; s_seen = 1'b0; mdl_lb_valid = 1'b0;
      end else begin
         if (bus.rvalid) begin
            bus.rvalid = 1'b0;
         end else if (bus.arready) begin
            bus.arready = 1'b0; s_pend = 1'b1; r_wait = cfg_r;
         end else if (!s_pend && bus.arvalid) begin
            if (!s_seen) begin s_seen = 1'b1; ar_wait = cfg_ar; end
            if (ar_wait == 0) begin
               bus.arready = 1'b1; s_addr = bus.araddr; ar_cnt++; s_seen = 1'b0;
            end else begin
               ar_wait--;
            end
         end
         if (s_pend) begin
            if (r_wait == 0) begin
               bus.rvalid = 1'b1;
               bus.rdata  = line_data(s_addr);
               bus.rresp  = (s_addr == err_addr) ? err_code : 2'b00;
               bus.rlast  = cfg_rlast;
               if (bus.rresp == 2'b00) begin
                  mdl_lb_valid = 1'b1; mdl_lb_line = s_addr[63:3];
               end else begin
                  mdl_lb_valid = 1'b0;
               end
               s_pend = 1'b0;
            end else begin
               r_wait--;
            end
         end
      end
   end

   // drive one fetch, hold it until if_ready (bounded), then look one more cycle
   task automatic do_fetch(input logic [63:0] a, output int lat, output logic [63:0] d,
                           output logic [1:0] rs, output int n_ar, output logic again);
      int ar0;
      @(negedge clk);
      ar0 = ar_cnt;
      bus.if_valid = 1'b1; bus.inst_addr = a; bus.if_size = 2'b10;
      lat = 0; d = 64'd0; rs = 2'b00; again = 1'b0;
      while (1) begin
         @(posedge clk); #1;
         lat++;
         if (bus.if_ready) break;
         if (lat >= 100) begin lat = -1; break; end
      end
      if (lat > 0) begin
         d = bus.if_data_read; rs = bus.if_resp;
         @(posedge clk); #1;
         again = bus.if_ready;
      end
      bus.if_valid = 1'b0;
      n_ar = ar_cnt - ar0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (bus.arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid: got %b expected 0", bus.arvalid); end
      n_chk++; if (bus.rready !== 1'b0) begin n_err++; $display("FAIL rst_rready: got %b expected 0", bus.rready); end
      n_chk++; if (bus.if_ready !== 1'b0) begin n_err++; $display("FAIL rst_if_ready: got %b expected 0", bus.if_ready); end
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if (bus.arvalid !== 1'b0 || bus.if_ready !== 1'b0 || bus.rready !== 1'b0) begin
            n_err++; $display("FAIL idle_quiet: arvalid=%b if_ready=%b rready=%b expected all 0", bus.arvalid, bus.if_ready, bus.rready);
         end
      end
      n_chk++; if (bus.araddr !== 64'd0) begin n_err++; $display("FAIL rst_araddr: got %h expected 0", bus.araddr); end
      n_chk++; if (bus.if_data_read !== 64'd0) begin n_err++; $display("FAIL rst_data: got %h expected 0", bus.if_data_read); end
      n_chk++; if (bus.if_resp !== 2'b00) begin n_err++; $display("FAIL rst_resp: got %b expected 00", bus.if_resp); end
      n_chk++; if (bus.arsize !== 3'b000) begin n_err++; $display("FAIL rst_arsize: got %b expected 000", bus.arsize); end
      n_chk++; if (ar_cnt !== 0) begin n_err++; $display("FAIL rst_no_ar: got %0d ARs expected 0", ar_cnt); end
   endtask

   task automatic test_basic();
      int lat, n_ar; logic [63:0] d; logic [1:0] rs; logic again;
      cfg_ar = 0; cfg_r = 0;
      do_fetch(64'h8000_0000, lat, d, rs, n_ar, again);
      n_chk++; if (lat !== 3) begin n_err++; $display("FAIL basic_latency: got %0d expected 3", lat); end
      n_chk++; if (d !== 64'h0000_0000_0010_0093) begin n_err++; $display("FAIL basic_data: got %h expected 0000000000100093", d); end
      n_chk++; if (rs !== 2'b00) begin n_err++; $display("FAIL basic_resp: got %b expected 00", rs); end
      n_chk++; if (again !== 1'b0) begin n_err++; $display("FAIL basic_pulse: if_ready %b in following cycle, expected 0", again); end
      n_chk++; if (n_ar !== 1) begin n_err++; $display("FAIL basic_ar_count: got %0d expected 1", n_ar); end
   endtask

   task automatic test_ar_stall();
      int lat, n_ar; logic [63:0] d; logic [1:0] rs; logic again;
      int exp_lat, exp_ar; logic [63:0] exp_d;
      cfg_ar = 4; cfg_r = 0;
      exp_d = 64'h0000_0000_0000_0013;
      exp_ar = model_hit(64'h8000_0004) ? 0 : 1;
      exp_lat = (exp_ar == 0) ? 1 : 7;
      fork
         do_fetch(64'h8000_0004, lat, d, rs, n_ar, again);
         begin
            @(posedge clk); #2;
            for (int i = 0; i < 5 && exp_ar == 1; i++) begin
               n_chk++;
               if (bus.arvalid !== 1'b1 || bus.araddr !== 64'h8000_0004 || bus.arsize !== 3'b010 ||
                   bus.arlen !== 8'd0 || bus.arburst !== 2'b01 || bus.arid !== 4'd0) begin
                  n_err++;
                  $display("FAIL ar_stable[%0d]: arvalid=%b araddr=%h arsize=%b arlen=%h arburst=%b arid=%h expected 1 80000004 010 00 01 0",
                           i, bus.arvalid, bus.araddr, bus.arsize, bus.arlen, bus.arburst, bus.arid);
               end
               @(posedge clk); #2;
            end
         end
      join
      n_chk++; if (lat !== exp_lat) begin n_err++; $display("FAIL stall_latency: got %0d expected %0d", lat, exp_lat); end
      n_chk++; if (d !== exp_d) begin n_err++; $display("FAIL stall_upper_lane: got %h expected %h", d, exp_d); end
      n_chk++; if (again !== 1'b0) begin n_err++; $display("FAIL stall_pulse: got %b expected 0", again); end
      n_chk++; if (n_ar !== exp_ar) begin n_err++; $display("FAIL stall_ar_count: got %0d expected %0d", n_ar, exp_ar); end
      cfg_ar = 0;
   endtask

   task automatic test_redirect();
      int ar0, cyc, n_rdy; logic [63:0] exp_d;
      cfg_ar = 0; cfg_r = 3;
      exp_d = expect_word(64'h8000_0100);
      @(negedge clk);
      ar0 = ar_cnt;
      bus.if_valid = 1'b1; bus.inst_addr = 64'h8000_0008; bus.if_size = 2'b10;
      cyc = 0; n_rdy = 0;
      do begin @(posedge clk); #1; cyc++; if (bus.if_ready) n_rdy++; end while (!bus.rready && cyc < 50);
      @(negedge clk); bus.inst_addr = 64'h8000_0100;
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!bus.if_ready && cyc < 100);
      n_chk++; if (bus.if_ready !== 1'b1) begin n_err++; $display("FAIL redirect_done: if_ready %b after %0d cycles, expected 1", bus.if_ready, cyc); end
      n_chk++; if (bus.if_data_read !== exp_d) begin n_err++; $display("FAIL redirect_data: got %h expected %h", bus.if_data_read, exp_d); end
      n_chk++; if ((ar_cnt - ar0) !== 2) begin n_err++; $display("FAIL redirect_ar_count: got %0d expected 2", ar_cnt - ar0); end
      n_chk++; if (n_rdy !== 0) begin n_err++; $display("FAIL redirect_early_ready: got %0d pulses expected 0", n_rdy); end
      @(posedge clk); #1;
      bus.if_valid = 1'b0;
      cfg_r = 0;
   endtask

   task automatic test_error();
      int lat, n_ar, exp_ar; logic [63:0] d; logic [1:0] rs; logic again;
      cfg_ar = 0; cfg_r = 0;
      err_addr = 64'h8000_0010; err_code = 2'b10;
      do_fetch(64'h8000_0010, lat, d, rs, n_ar, again);
      n_chk++; if (lat !== 3) begin n_err++; $display("FAIL err_latency: got %0d expected 3", lat); end
      n_chk++; if (rs !== 2'b10) begin n_err++; $display("FAIL err_resp: got %b expected 10", rs); end
      n_chk++; if (d !== expect_word(64'h8000_0010)) begin n_err++; $display("FAIL err_data: got %h expected %h", d, expect_word(64'h8000_0010)); end
      err_addr = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_ar = model_hit(64'h8000_0014) ? 0 : 1;
      do_fetch(64'h8000_0014, lat, d, rs, n_ar, again);
      n_chk++; if (n_ar !== exp_ar || exp_ar !== 1) begin n_err++; $display("FAIL err_refetch_ar: got %0d ARs expected 1", n_ar); end
      n_chk++; if (d !== expect_word(64'h8000_0014)) begin n_err++; $display("FAIL err_refetch_data: got %h expected %h", d, expect_word(64'h8000_0014)); end
   endtask

   task automatic test_line_buf();
      int lat, n_ar, exp_lat, exp_ar; logic [63:0] d; logic [1:0] rs; logic again; bit hit;
      cfg_ar = 0; cfg_r = 0;
      do_fetch(64'h8000_0020, lat, d, rs, n_ar, again);
      n_chk++; if (d !== expect_word(64'h8000_0020)) begin n_err++; $display("FAIL lb_first_data: got %h expected %h", d, expect_word(64'h8000_0020)); end
      hit = model_hit(64'h8000_0024);
      exp_lat = hit ? 1 : 3; exp_ar = hit ? 0 : 1;
      do_fetch(64'h8000_0024, lat, d, rs, n_ar, again);
      n_chk++; if (lat !== exp_lat) begin n_err++; $display("FAIL lb_latency: got %0d expected %0d", lat, exp_lat); end
      n_chk++; if (n_ar !== exp_ar) begin n_err++; $display("FAIL lb_ar_count: got %0d expected %0d", n_ar, exp_ar); end
      n_chk++; if (d !== expect_word(64'h8000_0024)) begin n_err++; $display("FAIL lb_data: got %h expected %h", d, expect_word(64'h8000_0024)); end
      n_chk++; if (rs !== 2'b00 || again !== 1'b0) begin n_err++; $display("FAIL lb_resp_pulse: resp=%b again=%b expected 00 0", rs, again); end
   endtask

   task automatic test_mid_reset();
      int lat, n_ar, cyc; logic [63:0] d; logic [1:0] rs; logic again;
      cfg_ar = 0; cfg_r = 5;
      @(negedge clk);
      bus.if_valid = 1'b1; bus.inst_addr = 64'h8000_0040; bus.if_size = 2'b10;
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!bus.rready && cyc < 50);
      rst = 1'b0;
      @(posedge clk); #1;
      n_chk++; if (bus.rready !== 1'b0 || bus.arvalid !== 1'b0 || bus.if_ready !== 1'b0) begin
         n_err++; $display("FAIL midrst_idle: rready=%b arvalid=%b if_ready=%b expected 0 0 0", bus.rready, bus.arvalid, bus.if_ready);
      end
      bus.if_valid = 1'b0;
      @(negedge clk); rst = 1'b1;
      cfg_r = 0;
      do_fetch(64'h8000_0040, lat, d, rs, n_ar, again);
      n_chk++; if (lat !== 3 || n_ar !== 1) begin n_err++; $display("FAIL midrst_refetch: lat=%0d ars=%0d expected 3 1", lat, n_ar); end
      n_chk++; if (d !== expect_word(64'h8000_0040)) begin n_err++; $display("FAIL midrst_data: got %h expected %h", d, expect_word(64'h8000_0040)); end
   endtask

   task automatic test_random();
      int lat, n_ar, exp_lat, exp_ar; logic [63:0] d, a, exp_d; logic [1:0] rs, exp_rs; logic again; bit hit;
      for (int i = 0; i < 40; i++) begin
         a = 64'h8000_0000 + 64'(4 * $urandom_range(0, 23));
         cfg_ar = $urandom_range(0, 3); cfg_r = $urandom_range(0, 3);
         cfg_rlast = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) begin
            err_addr = a; err_code = 2'($urandom_range(1, 3));
         end else begin
            err_addr = 64'hFFFF_FFFF_FFFF_FFFF;
         end
         hit = model_hit(a);
         exp_lat = hit ? 1 : 3 + cfg_ar + cfg_r;
         exp_ar  = hit ? 0 : 1;
         exp_rs  = (hit || err_addr != a) ? 2'b00 : err_code;
         exp_d   = expect_word(a);
         do_fetch(a, lat, d, rs, n_ar, again);
         n_chk++;
         if (lat !== exp_lat || d !== exp_d || rs !== exp_rs || n_ar !== exp_ar || again !== 1'b0) begin
            n_err++;
            $display("FAIL random[%0d] addr=%h: lat=%0d data=%h resp=%b ars=%0d again=%b expected %0d %h %b %0d 0",
                     i, a, lat, d, rs, n_ar, again, exp_lat, exp_d, exp_rs, exp_ar);
         end
      end
      err_addr = 64'hFFFF_FFFF_FFFF_FFFF; cfg_rlast = 1'b1;
   endtask

   initial begin
      logic [63:0] a0;
      a0 = 64'h8000_0000;
      mem[a0[63:3]] = 64'h0000_0013_0010_0093;
      bus.if_valid = 1'b0; bus.inst_addr = 64'd0; bus.if_size = 2'b00;
      test_reset();
      test_basic();
      test_ar_stall();
      test_redirect();
      test_error();
      test_line_buf();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #300000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ysyx_22040759_if_axi_rd.md
Name: ysyx_22040759_if_axi_rd

Overview:
- Instruction-fetch AXI4 read bridge. Sits directly upstream of the IF stage and converts its simple fetch request/response handshake (if_valid/if_ready/inst_addr/if_size/if_data_read/if_resp) into single-beat AXI4 AR/R transactions toward the crossbar.
- Returns the 32-bit instruction lane-aligned in bits [31:0] of the 64-bit response, for exactly one cycle per completed fetch.

Parameters:
- AXI_ID, 4'd0, constant arid driven on every request.
- ADDR_W, 64, fetch/AXI address width.
- DATA_W, 64, AXI data width. Only 64 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
- if_valid  in  1  IF fetch request valid.
- inst_addr  in  ADDR_W  fetch address (4-byte aligned).
- if_size  in  2  access size; 2'b10 = word.
- if_ready  out  1  one-cycle pulse: fetch complete, data/resp valid this cycle.
- if_data_read  out  DATA_W  instruction in [31:0], upper bits 0.
- if_resp  out  2  AXI response code of the returned beat.
- arvalid  out  1  AXI read address valid.
- arready  in  1  AXI read address ready.
- araddr  out  ADDR_W  AXI read address.
- arid  out  4  = AXI_ID.
- arlen  out  8  constant 8'd0.
- arsize  out  3  {1'b0, if_size latched}.
- arburst  out  2  constant 2'b01 (INCR).
- rvalid  in  1  AXI read data valid.
- rready  out  1  AXI read data ready.
- rdata  in  DATA_W  AXI read data.
- rresp  in  2  AXI read response.
- rlast  in  1  last beat; expected 1.
- rid  in  4  ignored.

Behaviour:
- Reset (rst==0 at posedge): state IDLE; arvalid, rready, if_ready = 0; araddr, if_data_read, if_resp = 0; latched address/size = 0.
- FSM states: IDLE, AR, R, DONE.
- IDLE: if if_valid, latch inst_addr/if_size, go to AR. Otherwise stay.
- AR: arvalid=1, araddr=latched address. On arvalid&arready, go to R. arvalid never drops before arready. araddr/arsize stay stable while arvalid is high.
- R: rready=1. On rvalid, capture data and resp, go to DONE.
  - Lane select: latched addr[2]==1 -> data = {32'b0, rdata[63:32]}, else {32'b0, rdata[31:0]}.
  - rresp is captured unchanged.
- DONE: registered outputs are presented.
  - If if_valid==1 and inst_addr == latched address: if_ready=1 for this cycle only, then go to IDLE.
  - Otherwise the IF redirected or dropped the request: discard the result, if_ready stays 0, go to IDLE. A new request is accepted the following cycle.
- if_ready is never high in IDLE, AR or R. It is never high for two consecutive cycles.
- Latency: if_valid at cycle 0 -> arvalid at 1. If arready at 1 and rvalid at 2, if_ready at 3. Total is 3 cycles plus slave stall cycles.
- One transaction outstanding at a time. No new AR is issued until the R beat returns.
- Changes to inst_addr during AR/R do not abort the AXI transaction. The mismatch is resolved in DONE.
- Error response (rresp != 2'b00): data is still returned with if_resp = rresp. Error handling is the consumer's job.
- rlast==0 on the beat is a protocol violation. The bridge treats the beat as final regardless.
- Reset mid-transaction: FSM returns to IDLE immediately and rready is deasserted. The slave is reset in the same cycle at system level.

Optional Feature:
- Macro YSYX_22040759_IF_LINE_BUF_EN.
- Enabled: adds a one-entry 64-bit line buffer holding rdata, tag = address[ADDR_W-1:3], plus a valid bit.
  - In IDLE, if if_valid and the buffer is valid and inst_addr[ADDR_W-1:3] matches the tag, go straight to DONE with lane-selected buffer data and if_resp=2'b00. No AXI traffic; if_ready follows one cycle after the request.
  - The buffer is filled on every OKAY R beat.
  - The buffer is invalidated on reset and on any non-OKAY response.
  - Self-modifying code is not supported.
- Disabled: no buffer; every fetch issues an AR.

Test Plan:
- Reset held 3 cycles, then released with if_valid=0 -> all outputs 0, no arvalid ever.
- inst_addr=0x80000000, arready=1 immediately, rdata=0x00000013_00100093 at cycle 2 -> if_ready at cycle 3, if_data_read=0x00100093, if_resp=0, single-cycle pulse.
- inst_addr=0x80000004, arready held low 4 cycles -> arvalid/araddr stable all 4 cycles, arsize=3'b010, arlen=0, arburst=01; upper lane 0x00000013 returned.
- Redirect: inst_addr changes 0x80000008 -> 0x80000100 while in R -> first beat discarded with no if_ready, new AR issued for 0x80000100.
- rresp=2'b10 on 0x80000010 -> if_ready=1, if_resp=2'b10. With LINE_BUF_EN, a following fetch of 0x80000014 issues an AR.
- LINE_BUF_EN: fetch 0x80000020, then 0x80000024 -> second fetch gives if_ready one cycle after the request, no arvalid, upper lane of the first rdata.
